lsu_dmem: RTL and testbench

Load/store unit sitting between the RV32I core execute stage and the word-wide data-memory port (`dmem_*`). It issues reads and writes on behalf of the core and handles byte/halfword alignment and sign/zero extension. Sub-word stores become read-modify-write sequences, because the memory port only writes full 32-bit words. It also checks alignment and raises an error response instead of touching memory.

---
 rtl/lsu_dmem.sv | 181 ++++++++++++++++++
 tb/tb_lsu_dmem.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem.sv
// lsu_dmem: RV32I load/store unit over a word-wide data-memory port.
// Define LSU_MMIO_EN to route addr[31:28]==MMIO_NIBBLE stores to the mmio_* strobe.
module lsu_dmem #(
  parameter logic [3:0] MMIO_NIBBLE = 4'hF
) (
  input  logic        sysclk,
  input  logic        nrst_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dmem_rd_addr,
  input  logic [31:0] dmem_rd_data,
  output logic [31:0] dmem_wr_addr,
  output logic [31:0] dmem_wr_data,
  output logic        dmem_wr_en,
  output logic        mmio_wr_en,
  output logic [31:0] mmio_wr_addr,
  output logic [31:0] mmio_wr_data
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, RESP
  } state_t;

`ifdef LSU_MMIO_EN
  localparam logic MMIO_ON = 1'b1;
`else
  localparam logic MMIO_ON = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        mmio_q, mmio_d;

  logic        bad_f3, misal, req_mmio, req_err;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;
  logic [31:0] wr_word;

  always_comb begin
    req_mmio = MMIO_ON && (req_addr[31:28] == MMIO_NIBBLE);
    if (req_we)
      bad_f3 = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      bad_f3 = (req_funct3[1:0] == 2'b11)
            || (req_funct3[2] && req_funct3[1]);
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0])
         || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err = bad_f3 || misal;
  end

  always_comb begin
    ld_b = dmem_rd_data[{off_q, 3'b000} +: 8];
    ld_h = dmem_rd_data[{off_q[1], 4'b0000} +: 16];
    unique case (f3_q)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_val = {24'b0, ld_b};
      3'b101:  ld_val = {16'b0, ld_h};
      default: ld_val = dmem_rd_data;
    endcase
  end

  // data_q holds the captured word for sub-word stores
  always_comb begin
    wr_word = wdata_q;
    unique case (f3_q[1:0])
      2'b00: begin
        wr_word = data_q;
        wr_word[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        wr_word = data_q;
        wr_word[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: wr_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    off_d   = off_q;
    f3_d    = f3_q;
    we_d    = we_q;
    err_d   = err_q;
    mmio_d  = mmio_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = {req_addr[31:2], 2'b00};
          off_d   = req_addr[1:0];
          f3_d    = req_funct3;
          we_d    = req_we;
          wdata_d = req_wdata;
          err_d   = req_err;
          mmio_d  = req_mmio && !req_err;
          data_d  = '0;
          if (req_err)
            state_d = RESP;
          else if (req_we && (req_funct3[1:0] == 2'b10 || req_mmio))
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        if (we_q) begin
          data_d  = dmem_rd_data;
          state_d = WRITE;
        end else begin
          if (!mmio_q)
            data_d = ld_val;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      mmio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      err_q   <= err_d;
      mmio_q  <= mmio_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_err     = resp_valid && err_q;
  assign resp_rdata   = (resp_valid && !we_q) ? data_q : '0;
  assign dmem_rd_addr = addr_q;
  assign dmem_wr_addr = addr_q;
  assign dmem_wr_data = wr_word;
  assign dmem_wr_en   = (state_q == WRITE) && !mmio_q;

`ifdef LSU_MMIO_EN
  assign mmio_wr_en   = (state_q == WRITE) && mmio_q;
  assign mmio_wr_addr = {addr_q[31:2], off_q};
  assign mmio_wr_data = wdata_q;
`else
  assign mmio_wr_en   = 1'b0;
  assign mmio_wr_addr = '0;
  assign mmio_wr_data = '0;
`endif

endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: directed checks of lsu_dmem loads, stores, errors, reset and MMIO.
// Expectations follow LSU_MMIO_EN when the bench is built with it.
module tb_lsu_dmem;

  logic        sysclk = 1'b0;
  logic        nrst_in;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] dmem_rd_addr, dmem_rd_data;
  logic [31:0] dmem_wr_addr, dmem_wr_data;
  logic        dmem_wr_en;
  logic        mmio_wr_en;
  logic [31:0] mmio_wr_addr, mmio_wr_data;

  always #5 sysclk = ~sysclk;

  lsu_dmem dut (
    .sysclk       (sysclk),
    .nrst_in      (nrst_in),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dmem_rd_addr (dmem_rd_addr),
    .dmem_rd_data (dmem_rd_data),
    .dmem_wr_addr (dmem_wr_addr),
    .dmem_wr_data (dmem_wr_data),
    .dmem_wr_en   (dmem_wr_en),
    .mmio_wr_en   (mmio_wr_en),
    .mmio_wr_addr (mmio_wr_addr),
    .mmio_wr_data (mmio_wr_data)
  );

  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  assign dmem_rd_data = mem[dmem_rd_addr[7:2]];

  always @(posedge sysclk) begin
    if (pre_en)
      mem[pre_idx] <= pre_val;
    else if (dmem_wr_en)
      mem[dmem_wr_addr[7:2]] <= dmem_wr_data;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    @(negedge sysclk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge sysclk);
    #1 pre_en = 1'b0;
  endtask

  int          r_lat, r_nwr, r_nmm;
  logic [31:0] r_rdata, r_wa, r_wd, r_ma, r_md;
  logic        r_err;

  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    @(negedge sysclk);
    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(posedge sysclk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    r_lat = 0; r_nwr = 0; r_nmm = 0; r_rdata = 'x; r_err = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sysclk);
      if (dmem_wr_en) begin
        r_nwr++; r_wa = dmem_wr_addr; r_wd = dmem_wr_data;
      end
      if (mmio_wr_en) begin
        r_nmm++; r_ma = mmio_wr_addr; r_md = mmio_wr_data;
      end
      if (resp_valid) begin
        r_lat = k; r_rdata = resp_rdata; r_err = resp_err;
        chk("ready_in_resp", {31'b0, req_ready}, 32'd0);
        break;
      end
    end
  endtask

  task automatic expect_resp(input string tag, input int lat,
                             input logic [31:0] rd, input logic er,
                             input int nwr);
    chk({tag, "_lat"}, 32'(r_lat), 32'(lat));
    chk({tag, "_rdata"}, r_rdata, rd);
    chk({tag, "_err"}, {31'b0, r_err}, {31'b0, er});
    chk({tag, "_nwr"}, 32'(r_nwr), 32'(nwr));
  endtask

  initial begin
    int nwr_rst, nresp_rst;
    nrst_in = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0;
    #12;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_wr_en", {31'b0, dmem_wr_en}, 32'd0);
    chk("rst_rd_addr", dmem_rd_addr, 32'd0);
    chk("rst_mmio_en", {31'b0, mmio_wr_en}, 32'd0);
    @(negedge sysclk);
    nrst_in = 1'b1;

    poke(6'd4, 32'h8081_7F01);
    run_req(1'b0, 3'b000, 32'h13, 32'h0);
    expect_resp("lb13", 2, 32'hFFFF_FF80, 1'b0, 0);
    run_req(1'b0, 3'b100, 32'h13, 32'h0);
    expect_resp("lbu13", 2, 32'h0000_0080, 1'b0, 0);
    run_req(1'b0, 3'b001, 32'h12, 32'h0);
    expect_resp("lh12", 2, 32'hFFFF_8081, 1'b0, 0);
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    expect_resp("lw10", 2, 32'h8081_7F01, 1'b0, 0);
    run_req(1'b0, 3'b101, 32'h10, 32'h0);
    expect_resp("lhu10", 2, 32'h0000_7F01, 1'b0, 0);
    run_req(1'b0, 3'b000, 32'h11, 32'h0);
    expect_resp("lb11", 2, 32'h0000_007F, 1'b0, 0);
    chk("rd_addr_hold", dmem_rd_addr, 32'h10);

    poke(6'd4, 32'h1122_3344);
    run_req(1'b1, 3'b000, 32'h11, 32'hFFFF_FFAA);
    expect_resp("sb11", 3, 32'h0, 1'b0, 1);
    chk("sb11_wa", r_wa, 32'h10);
    chk("sb11_wd", r_wd, 32'h1122_AA44);
    chk("sb11_mem", mem[4], 32'h1122_AA44);

    run_req(1'b1, 3'b001, 32'h12, 32'h1234_BEEF);
    expect_resp("sh12", 3, 32'h0, 1'b0, 1);
    chk("sh12_mem", mem[4], 32'hBEEF_AA44);
    run_req(1'b1, 3'b010, 32'h14, 32'hDEAD_BEEF);
    expect_resp("sw14", 2, 32'h0, 1'b0, 1);
    chk("sw14_wa", r_wa, 32'h14);
    chk("sw14_mem", mem[5], 32'hDEAD_BEEF);

    run_req(1'b0, 3'b010, 32'h11, 32'h0);
    expect_resp("lw11_mis", 1, 32'h0, 1'b1, 0);
    run_req(1'b1, 3'b001, 32'h13, 32'h5555);
    expect_resp("sh13_mis", 1, 32'h0, 1'b1, 0);
    run_req(1'b0, 3'b011, 32'h10, 32'h0);
    expect_resp("ld_f3_011", 1, 32'h0, 1'b1, 0);
    run_req(1'b1, 3'b100, 32'h10, 32'h77);
    expect_resp("st_f3_100", 1, 32'h0, 1'b1, 0);
    chk("err_mem_kept", mem[4], 32'hBEEF_AA44);

    @(negedge sysclk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge sysclk);
    #1 req_valid = 1'b0;
    @(negedge sysclk);
    nrst_in = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    nwr_rst = 0; nresp_rst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge sysclk);
      if (k == 1) nrst_in = 1'b1;
      if (dmem_wr_en) nwr_rst++;
      if (resp_valid) nresp_rst++;
    end
    chk("midrst_nwr", 32'(nwr_rst), 32'd0);
    chk("midrst_nresp", 32'(nresp_rst), 32'd0);
    chk("midrst_ready_after", {31'b0, req_ready}, 32'd1);
    chk("midrst_mem", mem[4], 32'hBEEF_AA44);

    poke(6'd1, 32'h0);
    run_req(1'b1, 3'b010, 32'hF000_0004, 32'h0000_1234);
`ifdef LSU_MMIO_EN
    expect_resp("mmio_sw", 2, 32'h0, 1'b0, 0);
    chk("mmio_npulse", 32'(r_nmm), 32'd1);
    chk("mmio_addr", r_ma, 32'hF000_0004);
    chk("mmio_data", r_md, 32'h0000_1234);
    chk("mmio_mem_kept", mem[1], 32'h0);
`else
    expect_resp("mmio_sw", 2, 32'h0, 1'b0, 1);
    chk("mmio_npulse", 32'(r_nmm), 32'd0);
    chk("mmio_dmem_wa", r_wa, 32'hF000_0004);
    chk("mmio_dmem_mem", mem[1], 32'h0000_1234);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
